adc_reader: RTL and testbench

Synthesizable master for the ADS7883-style serial ADC. It generates chip-select and the serial ADC clock, captures the MSB-first serial sample stream, and presents parallel samples on a ready/valid interface. It is the acquisition front end feeding the sample buffer ahead of the FFT core.

---
 rtl/adc_reader_pkg.sv | 20 ++
 rtl/adc_sclk_gen.sv | 47 ++++
 rtl/adc_reader.sv | 165 ++++++++++++++++
 tb/tb_adc_reader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : adc_reader_pkg
// Brief    : Shared state encoding and defaults for the serial ADC reader.
// Revision : 1.0 - initial release
// ============================================================================
package adc_reader_pkg;

    localparam int c_DEFAULT_WIDTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CS_HIGH = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : adc_sclk_gen
// Brief    : Divided serial clock with one-cycle rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int                 c_CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sclk;
    logic               w_wrap;

    // Strobes mark the cycle in which the registered clock is about to toggle.
    assign w_wrap = i_enable && (r_cnt == c_CNT_LAST);
    assign o_rise = w_wrap && !r_sclk;
    assign o_fall = w_wrap && r_sclk;
    assign o_sclk = r_sclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_enable) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_reader.sv
`default_nettype none
// ============================================================================
// Module   : adc_reader
// Brief    : ADS7883-style serial ADC master with ready/valid sample output.
// Revision : 1.0 - initial release
// ============================================================================
module adc_reader
    import adc_reader_pkg::*;
#(
    parameter int WIDTH       = c_DEFAULT_WIDTH,
    parameter int CLK_DIV     = 2,
    parameter int FRAME_BITS  = 14,
    parameter int NUM_SAMPLES = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sd,
    output logic             adc_cs,
    output logic             adc_sclk,
    output logic [WIDTH-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int                  c_SCNT_W     = $clog2(NUM_SAMPLES + 1);
    localparam int                  c_BCNT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_LAST  = c_SCNT_W'(NUM_SAMPLES);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST  = c_BCNT_W'(FRAME_BITS);
    localparam logic [c_BCNT_W-1:0] c_BCNT_FIRST = c_BCNT_W'(1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LSB   = c_BCNT_W'(WIDTH);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_sclk_en;
    logic                w_rise;
    logic                w_fall;
    logic                w_sclk;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [c_SCNT_W-1:0] r_smp_cnt;
    logic [c_SCNT_W-1:0] w_smp_cnt_inc;
    logic [WIDTH-1:0]    r_shift;
    logic [WIDTH-1:0]    r_data;
    logic                r_valid;
    logic                r_overrun;
    logic                r_busy;
    logic                r_done;
    logic                r_cs;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .i_enable (w_sclk_en),
        .o_sclk   (w_sclk),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    assign w_smp_cnt_inc = r_smp_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_sclk_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_CS_HIGH;
                end
            end
            ST_CS_HIGH: begin
                w_sclk_en = 1'b1;
                if (w_fall) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_sclk_en = 1'b1;
                // r_bit_cnt counts rising edges; the frame ends on the fall after the last one.
                if (w_fall && (r_bit_cnt == c_BCNT_LAST)) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_next = (w_smp_cnt_inc == c_SCNT_LAST) ? ST_DONE : ST_CS_HIGH;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Control outputs are registered from the next state so they align with r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cs    <= (w_state_next != ST_SHIFT);
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_smp_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == ST_CS_HIGH) begin
                r_bit_cnt <= '0;
            end else if ((r_state == ST_SHIFT) && w_rise) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                // Edge 0 carries the ADC leading zero; trailing edges are padding.
                if ((r_bit_cnt >= c_BCNT_FIRST) && (r_bit_cnt <= c_BCNT_LSB)) begin
                    r_shift <= {r_shift[WIDTH-2:0], sd};
                end
            end

            if (r_state == ST_IDLE) begin
                r_smp_cnt <= '0;
            end else if (r_state == ST_CAPTURE) begin
                r_smp_cnt <= w_smp_cnt_inc;
            end
        end
    end

    // Output handshake runs independently of the frame engine; a capture always wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            if (r_valid && !sample_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign adc_cs       = r_cs;
    assign adc_sclk     = w_sclk;
    assign sample_data  = r_data;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_reader
// Brief    : Self-checking bench: three readers with a behavioural ADC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_reader;

    localparam int WIDTH      = 12;
    localparam int FRAME_BITS = 14;
    localparam int N_DUT      = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_DUT-1:0] start;
    logic [N_DUT-1:0] sample_ready;
    logic [N_DUT-1:0] adc_cs;
    logic [N_DUT-1:0] adc_sclk;
    logic [N_DUT-1:0] sample_valid;
    logic [N_DUT-1:0] busy;
    logic [N_DUT-1:0] done;
    logic [N_DUT-1:0] overrun;
    logic [WIDTH-1:0] sample_data [N_DUT];
    logic [WIDTH-1:0] adc_vals [N_DUT][8];

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: CLK_DIV=2, 4 samples; instance 1: CLK_DIV=1, 1 sample; instance 2: CLK_DIV=3, 1 sample.
    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int DIV = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);
        localparam int NS  = (gi == 0) ? 4 : 1;

        logic             sd;
        logic [WIDTH-1:0] cur;
        logic             prev_cs;
        logic             prev_sclk;
        int               conv_idx, bit_k, got_n, done_cnt, done_t;
        int               cs_run, cs_low_len, last_rise, sclk_period, sclk_idle_bad;
        logic [WIDTH-1:0] got_d [16];
        int               got_t [16];

        adc_reader #(
            .WIDTH       (WIDTH),
            .CLK_DIV     (DIV),
            .FRAME_BITS  (FRAME_BITS),
            .NUM_SAMPLES (NS)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start[gi]),
            .sd           (sd),
            .adc_cs       (adc_cs[gi]),
            .adc_sclk     (adc_sclk[gi]),
            .sample_data  (sample_data[gi]),
            .sample_valid (sample_valid[gi]),
            .sample_ready (sample_ready[gi]),
            .busy         (busy[gi]),
            .done         (done[gi]),
            .overrun      (overrun[gi])
        );

        // ADC: converts on cs fall, drives a leading zero, then one bit after each sclk fall.
        always @(negedge clk) begin
            if (reset) begin
                sd <= 1'b0; cur <= '0; prev_cs <= 1'b1; prev_sclk <= 1'b0;
                conv_idx <= 0; bit_k <= 0; got_n <= 0; done_cnt <= 0; done_t <= 0;
                cs_run <= 0; cs_low_len <= 0; last_rise <= -1; sclk_period <= 0; sclk_idle_bad <= 0;
            end else begin
                if (adc_cs[gi]) begin
                    bit_k <= 0;
                    sd    <= 1'b0;
                end else if (prev_cs) begin
                    cur      <= adc_vals[gi][conv_idx & 7];
                    conv_idx <= conv_idx + 1;
                    bit_k    <= 0;
                    sd       <= 1'b0;
                end else if (prev_sclk && !adc_sclk[gi]) begin
                    bit_k <= bit_k + 1;
                    sd    <= (bit_k + 1 <= WIDTH) ? cur[WIDTH - (bit_k + 1)] : 1'b0;
                end

                if (sample_valid[gi] && sample_ready[gi] && got_n < 16) begin
                    got_d[got_n] <= sample_data[gi];
                    got_t[got_n] <= cyc;
                    got_n        <= got_n + 1;
                end
                if (done[gi]) begin
                    done_cnt <= done_cnt + 1;
                    done_t   <= cyc;
                end
                if (!adc_cs[gi]) begin
                    cs_run <= cs_run + 1;
                end else if (!prev_cs) begin
                    cs_low_len <= cs_run;
                    cs_run     <= 0;
                end
                if (adc_sclk[gi] && !prev_sclk) begin
                    if (last_rise >= 0) sclk_period <= cyc - last_rise;
                    last_rise <= cyc;
                end
                if (!busy[gi] && adc_sclk[gi]) sclk_idle_bad <= sclk_idle_bad + 1;
                prev_cs   <= adc_cs[gi];
                prev_sclk <= adc_sclk[gi];
            end
        end
    end

    function automatic int sample_period(input int div);
        return (1 + FRAME_BITS) * 2 * div + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [N_DUT-1:0] mask, output int t);
        step();
        start = mask;
        step();
        start = '0;
        t = cyc;
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 5000 && cyc < t; i++) step();
    endtask

    task automatic wait_done0();
        for (int i = 0; i < 600 && g_dut[0].done_cnt == 0; i++) step();
        step();
        step();
    endtask

    initial begin
        logic [WIDTH-1:0] exp_v [4];
        int               t_start;
        int               t_dummy;

        reset        = 1'b1;
        start        = '0;
        sample_ready = '1;
        for (int d = 0; d < N_DUT; d++)
            for (int k = 0; k < 8; k++) adc_vals[d][k] = '0;
        do_reset();

        check("rst_cs",      32'(adc_cs[0]),       32'd1);
        check("rst_sclk",    32'(adc_sclk[0]),     32'd0);
        check("rst_data",    32'(sample_data[0]),  32'd0);
        check("rst_valid",   32'(sample_valid[0]), 32'd0);
        check("rst_busy",    32'(busy[0]),         32'd0);
        check("rst_done",    32'(done[0]),         32'd0);
        check("rst_overrun", 32'(overrun[0]),      32'd0);

        // Directed four-sample run with boundary codes.
        exp_v = '{12'h000, 12'hFFF, 12'h800, 12'h001};
        for (int k = 0; k < 4; k++) adc_vals[0][k] = exp_v[k];
        pulse_start(3'b001, t_start);
        check("busy_rise", 32'(busy[0]), 32'd1);
        wait_done0();
        check("t1_count", 32'(g_dut[0].got_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_data%0d", k), 32'(g_dut[0].got_d[k]), 32'(exp_v[k]));
            check($sformatf("t1_time%0d", k), 32'(g_dut[0].got_t[k] - t_start), 32'(sample_period(2) * (k + 1)));
        end
        check("t1_done_cnt",  32'(g_dut[0].done_cnt), 32'd1);
        check("t1_done_time", 32'(g_dut[0].done_t), 32'(g_dut[0].got_t[3]));
        check("t1_busy_end",  32'(busy[0]), 32'd0);
        check("t1_cs_low",    32'(g_dut[0].cs_low_len), 32'(FRAME_BITS * 4));
        check("t1_sclk_per",  32'(g_dut[0].sclk_period), 32'd4);

        // Random samples, with start pulses while busy that must be ignored.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_v[k]       = WIDTH'($urandom);
            adc_vals[0][k] = exp_v[k];
        end
        pulse_start(3'b001, t_start);
        wait_cyc(t_start + 30);
        pulse_start(3'b001, t_dummy);
        wait_cyc(t_start + 150);
        pulse_start(3'b001, t_dummy);
        wait_done0();
        check("t2_count",    32'(g_dut[0].got_n), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t2_data%0d", k), 32'(g_dut[0].got_d[k]), 32'(exp_v[k]));
        check("t2_done_cnt", 32'(g_dut[0].done_cnt), 32'd1);
        wait_cyc(cyc + 70);
        check("t2_no_rerun", 32'(busy[0]), 32'd0);

        // Single-sample runs at CLK_DIV=1 and CLK_DIV=3.
        do_reset();
        adc_vals[1][0] = 12'hABC;
        exp_v[0]       = WIDTH'($urandom);
        adc_vals[2][0] = exp_v[0];
        pulse_start(3'b110, t_start);
        for (int i = 0; i < 300 && (g_dut[1].done_cnt == 0 || g_dut[2].done_cnt == 0); i++) step();
        step();
        check("t3_d1_count", 32'(g_dut[1].got_n), 32'd1);
        check("t3_d1_data",  32'(g_dut[1].got_d[0]), 32'hABC);
        check("t3_d1_time",  32'(g_dut[1].got_t[0] - t_start), 32'(sample_period(1)));
        check("t3_d1_per",   32'(g_dut[1].sclk_period), 32'd2);
        check("t3_d1_cs",    32'(g_dut[1].cs_low_len), 32'(FRAME_BITS * 2));
        check("t3_d1_done",  32'(g_dut[1].done_cnt), 32'd1);
        check("t3_d2_data",  32'(g_dut[2].got_d[0]), 32'(exp_v[0]));
        check("t3_d2_time",  32'(g_dut[2].got_t[0] - t_start), 32'(sample_period(3)));
        check("t3_d2_per",   32'(g_dut[2].sclk_period), 32'd6);
        check("t3_d2_cs",    32'(g_dut[2].cs_low_len), 32'(FRAME_BITS * 6));
        check("t3_d2_done",  32'(g_dut[2].done_cnt), 32'd1);
        for (int d = 0; d < N_DUT; d++) begin
            case (d)
                0: check("idle_sclk0", 32'(g_dut[0].sclk_idle_bad), 32'd0);
                1: check("idle_sclk1", 32'(g_dut[1].sclk_idle_bad), 32'd0);
                default: check("idle_sclk2", 32'(g_dut[2].sclk_idle_bad), 32'd0);
            endcase
        end

        // Backpressure: two unaccepted samples raise sticky overrun.
        do_reset();
        adc_vals[0][0] = 12'h123;
        adc_vals[0][1] = 12'h456;
        adc_vals[0][2] = WIDTH'($urandom);
        adc_vals[0][3] = WIDTH'($urandom);
        sample_ready[0] = 1'b0;
        pulse_start(3'b001, t_start);
        wait_cyc(t_start + sample_period(2) + 1);
        check("t4_valid1",   32'(sample_valid[0]), 32'd1);
        check("t4_data1",    32'(sample_data[0]), 32'h123);
        check("t4_ovr0",     32'(overrun[0]), 32'd0);
        wait_cyc(t_start + 2 * sample_period(2) + 1);
        check("t4_data2",    32'(sample_data[0]), 32'h456);
        check("t4_ovr1",     32'(overrun[0]), 32'd1);
        sample_ready[0] = 1'b1;
        step();
        step();
        check("t4_valid_clr", 32'(sample_valid[0]), 32'd0);
        check("t4_ovr_hold",  32'(overrun[0]), 32'd1);
        wait_done0();
        check("t4_ovr_end",   32'(overrun[0]), 32'd1);
        check("t4_done_cnt",  32'(g_dut[0].done_cnt), 32'd1);

        // Reset during the second frame's shift, then a clean run.
        do_reset();
        sample_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) adc_vals[0][k] = WIDTH'($urandom);
        pulse_start(3'b001, t_start);
        wait_cyc(t_start + sample_period(2) + 20);
        check("t5_pre_cs",    32'(adc_cs[0]), 32'd0);
        check("t5_pre_valid", 32'(sample_valid[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_cs",    32'(adc_cs[0]), 32'd1);
        check("t5_rst_valid", 32'(sample_valid[0]), 32'd0);
        check("t5_rst_sclk",  32'(adc_sclk[0]), 32'd0);
        check("t5_rst_busy",  32'(busy[0]), 32'd0);
        step();
        step();
        reset = 1'b0;
        exp_v = '{12'h5A5, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom)};
        for (int k = 0; k < 4; k++) adc_vals[0][k] = exp_v[k];
        sample_ready[0] = 1'b1;
        pulse_start(3'b001, t_start);
        wait_done0();
        check("t5_count", 32'(g_dut[0].got_n), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t5_data%0d", k), 32'(g_dut[0].got_d[k]), 32'(exp_v[k]));
        check("t5_done_cnt", 32'(g_dut[0].done_cnt), 32'd1);
        check("t5_overrun",  32'(overrun[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
